mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory slave with combinational reads and a delayed-data write FSM.
// Define MEM_RESP_FWD_EN to forward pending write data to reads of the same address.
module mem_responder #(
    parameter int BITS_DATA     = 32,
    parameter int BITS_ADDR     = 16,
    parameter int DEPTH_LOG2    = 10,
    parameter int WR_DATA_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITS_ADDR-1:0] MAR,
    input  logic [BITS_DATA-1:0] MBR_W,
    input  logic                 write,
    output logic [BITS_DATA-1:0] MBR_R,
    output logic                 busy,
    output logic                 err,
    output logic [15:0]          wr_count,
    output logic [1:0]           o_dbg_state
);

    // Handshake: a transaction starts on the edge where write is 1 and was 0 on
    // the previous edge while idle; busy stays high until the commit edge.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam bit       ZERO_DELAY = (WR_DATA_DELAY == 0);
    localparam logic [2:0] DELAY_LD = 3'(WR_DATA_DELAY);

    logic [BITS_DATA-1:0] r_mem [2**DEPTH_LOG2];

    state_t               r_state;
    state_t               w_next;
    logic [2:0]           r_cnt;
    logic                 r_write_q;
    logic                 r_wb_valid;
    logic [BITS_ADDR-1:0] r_wb_addr;
    logic [BITS_DATA-1:0] r_wb_data;
    logic                 r_err;
    logic [15:0]          r_wr_count;

    logic                 w_rise;
    logic                 w_mar_in_range;
    logic                 w_wb_in_range;
    logic                 w_commit;
    logic [BITS_DATA-1:0] w_arr_rdata;

    assign w_rise   = write & ~r_write_q;
    assign w_commit = (r_state == S_COMMIT) && r_wb_valid;

    generate
        if (BITS_ADDR > DEPTH_LOG2) begin : g_range
            assign w_mar_in_range = (MAR[BITS_ADDR-1:DEPTH_LOG2] == '0);
            assign w_wb_in_range  = (r_wb_addr[BITS_ADDR-1:DEPTH_LOG2] == '0);
        end else begin : g_full
            assign w_mar_in_range = 1'b1;
            assign w_wb_in_range  = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_next = ZERO_DELAY ? S_COMMIT : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd1) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= 3'd0;
            r_write_q  <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
            r_wr_count <= 16'd0;
        end else begin
            r_write_q <= write;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_wb_addr <= MAR;
                        if (ZERO_DELAY) begin
                            r_wb_data  <= MBR_W;
                            r_wb_valid <= 1'b1;
                        end else begin
                            r_cnt <= DELAY_LD;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_wb_data  <= MBR_W;
                        r_wb_valid <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_wb_valid <= 1'b0;
                    if (w_commit) begin
                        if (w_wb_in_range) begin
                            r_wr_count <= r_wr_count + 16'd1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The array has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (!reset && w_commit && w_wb_in_range) begin
            r_mem[r_wb_addr[DEPTH_LOG2-1:0]] <= r_wb_data;
        end
    end

    assign w_arr_rdata = w_mar_in_range ? r_mem[MAR[DEPTH_LOG2-1:0]] : '0;

`ifdef MEM_RESP_FWD_EN
    assign MBR_R = (r_wb_valid && (MAR == r_wb_addr)) ? r_wb_data : w_arr_rdata;
`else
    assign MBR_R = w_arr_rdata;
`endif

    assign err      = r_err;
    assign wr_count = r_wr_count;

endmodule
